// File: rtl/bulls_cows_solver.sv
// Automatic Bulls-and-Cows guesser: searches for the next distinct-digit guess consistent
// with all feedback so far. Define BULLS_HEX_DIGITS_EN for hex digits 0-F.
module bulls_cows_solver #(
  parameter int unsigned MAX_GUESS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        result_valid,
  input  logic [3:0]  a_cnt,
  input  logic [3:0]  b_cnt,
  output logic [15:0] guess,
  output logic        guess_valid,
  output logic        busy,
  output logic        solved,
  output logic        fail,
  output logic [3:0]  guess_num
);

`ifdef BULLS_HEX_DIGITS_EN
  localparam logic [15:0] LastCand = 16'hFFFF;
`else
  localparam logic [15:0] LastCand = 16'h9999;
`endif

  typedef enum logic [2:0] {StIdle, StSearch, StPresent, StDone, StFail} state_e;

  function automatic logic [15:0] next_cand(input logic [15:0] c);
`ifdef BULLS_HEX_DIGITS_EN
    return c + 16'd1;
`else
    logic [15:0] r;
    logic        carry;
    r     = c;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
`endif
  endfunction

  function automatic logic distinct(input logic [15:0] c);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        if (c[4*i +: 4] == c[4*j +: 4]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  function automatic logic [3:0] score_a(input logic [15:0] c, input logic [15:0] g);
    logic [3:0] a;
    a = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (c[4*i +: 4] == g[4*i +: 4]) a = a + 4'd1;
    end
    return a;
  endfunction

  // Candidate digits are distinct, so each guess digit matches at most one other position.
  function automatic logic [3:0] score_b(input logic [15:0] c, input logic [15:0] g);
    logic [3:0] b;
    b = 4'd0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (i != j && g[4*i +: 4] == c[4*j +: 4]) b = b + 4'd1;
      end
    end
    return b;
  endfunction

  state_e             state_q, state_d;
  logic [15:0]        cand_q, cand_d;
  logic               init_q, init_d;
  logic [15:0]        guess_q, guess_d;
  logic               guess_valid_q, guess_valid_d;
  logic               busy_q, busy_d;
  logic               solved_q, solved_d;
  logic               fail_q, fail_d;
  logic [3:0]         guess_num_q, guess_num_d;
  logic [MAX_GUESS-1:0] hist_valid_q, hist_valid_d;
  logic [15:0]        hist_g_q [MAX_GUESS];
  logic [15:0]        hist_g_d [MAX_GUESS];
  logic [3:0]         hist_a_q [MAX_GUESS];
  logic [3:0]         hist_a_d [MAX_GUESS];
  logic [3:0]         hist_b_q [MAX_GUESS];
  logic [3:0]         hist_b_d [MAX_GUESS];
  logic               hit;

  always_comb begin
    hit = distinct(cand_q);
    for (int i = 0; i < int'(MAX_GUESS); i++) begin
      if (hist_valid_q[i] && (score_a(cand_q, hist_g_q[i]) != hist_a_q[i] ||
                              score_b(cand_q, hist_g_q[i]) != hist_b_q[i])) begin
        hit = 1'b0;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    init_d        = init_q;
    guess_d       = guess_q;
    guess_valid_d = guess_valid_q;
    busy_d        = busy_q;
    solved_d      = solved_q;
    fail_d        = fail_q;
    guess_num_d   = guess_num_q;
    hist_valid_d  = hist_valid_q;
    hist_g_d      = hist_g_q;
    hist_a_d      = hist_a_q;
    hist_b_d      = hist_b_q;
    case (state_q)
      StIdle, StDone, StFail: begin
        if (start) begin
          state_d      = StSearch;
          cand_d       = 16'd0;
          init_d       = 1'b1;
          guess_d      = 16'd0;
          busy_d       = 1'b1;
          solved_d     = 1'b0;
          fail_d       = 1'b0;
          guess_num_d  = 4'd0;
          hist_valid_d = '0;
        end
      end
      StSearch: begin
        // One settling cycle after start before candidate 0 is judged.
        if (init_q) begin
          init_d = 1'b0;
        end else if (hit) begin
          guess_d       = cand_q;
          guess_valid_d = 1'b1;
          state_d       = StPresent;
        end else if (cand_q == LastCand) begin
          state_d = StFail;
          fail_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cand_d = next_cand(cand_q);
        end
      end
      StPresent: begin
        if (result_valid && guess_valid_q) begin
          guess_valid_d = 1'b0;
          guess_num_d   = guess_num_q + 4'd1;
          for (int i = 0; i < int'(MAX_GUESS); i++) begin
            if (4'(i) == guess_num_q) begin
              hist_valid_d[i] = 1'b1;
              hist_g_d[i]     = guess_q;
              hist_a_d[i]     = a_cnt;
              hist_b_d[i]     = b_cnt;
            end
          end
          if (a_cnt == 4'd4) begin
            state_d  = StDone;
            solved_d = 1'b1;
            busy_d   = 1'b0;
          end else if (guess_num_q + 4'd1 == 4'(MAX_GUESS) || cand_q == LastCand) begin
            state_d = StFail;
            fail_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = StSearch;
            cand_d  = next_cand(cand_q);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      cand_q        <= 16'd0;
      init_q        <= 1'b0;
      guess_q       <= 16'd0;
      guess_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      solved_q      <= 1'b0;
      fail_q        <= 1'b0;
      guess_num_q   <= 4'd0;
      hist_valid_q  <= '0;
      for (int i = 0; i < int'(MAX_GUESS); i++) begin
        hist_g_q[i] <= 16'd0;
        hist_a_q[i] <= 4'd0;
        hist_b_q[i] <= 4'd0;
      end
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      init_q        <= init_d;
      guess_q       <= guess_d;
      guess_valid_q <= guess_valid_d;
      busy_q        <= busy_d;
      solved_q      <= solved_d;
      fail_q        <= fail_d;
      guess_num_q   <= guess_num_d;
      hist_valid_q  <= hist_valid_d;
      hist_g_q      <= hist_g_d;
      hist_a_q      <= hist_a_d;
      hist_b_q      <= hist_b_d;
    end
  end

  assign guess       = guess_q;
  assign guess_valid = guess_valid_q;
  assign busy        = busy_q;
  assign solved      = solved_q;
  assign fail        = fail_q;
  assign guess_num   = guess_num_q;

endmodule

// File: tb/tb_bulls_cows_solver.sv
// Directed bench for bulls_cows_solver: expected guesses are queued at game start and
// popped when guess_valid rises; a second instance with MAX_GUESS=2 covers the guess limit.
module tb_bulls_cows_solver;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        result_valid = 1'b0;
  logic [3:0]  a_cnt = 4'd0;
  logic [3:0]  b_cnt = 4'd0;
  logic        sel = 1'b0;

  logic [15:0] g1, g2, g;
  logic        gv1, gv2, gv, bz1, bz2, bz, sv1, sv2, sv, fl1, fl2, fl;
  logic [3:0]  n1, n2, num;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  bulls_cows_solver #(.MAX_GUESS(10)) dut (
    .clk(clk), .rst(rst), .start(start & ~sel), .result_valid(result_valid & ~sel),
    .a_cnt(a_cnt), .b_cnt(b_cnt), .guess(g1), .guess_valid(gv1), .busy(bz1),
    .solved(sv1), .fail(fl1), .guess_num(n1)
  );

  bulls_cows_solver #(.MAX_GUESS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start & sel), .result_valid(result_valid & sel),
    .a_cnt(a_cnt), .b_cnt(b_cnt), .guess(g2), .guess_valid(gv2), .busy(bz2),
    .solved(sv2), .fail(fl2), .guess_num(n2)
  );

  assign g   = sel ? g2 : g1;
  assign gv  = sel ? gv2 : gv1;
  assign bz  = sel ? bz2 : bz1;
  assign sv  = sel ? sv2 : sv1;
  assign fl  = sel ? fl2 : fl1;
  assign num = sel ? n2 : n1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [3:0] a, input logic [3:0] b);
    a_cnt        = a;
    b_cnt        = b;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
  endtask

  // exp_n < 0 skips the latency comparison.
  task automatic expect_guess(input string tag, input int exp_n);
    int n;
    logic [15:0] e;
    n = 0;
    while (!gv && n < 20000) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(gv), 32'd1);
    if (exp_n >= 0) check({tag, "_latency"}, n, exp_n);
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_guess"}, 32'(g), 32'(e));
    end
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (bz && n < 20000) begin
      tick();
      n++;
    end
    check({tag, "_ended"}, 32'(bz), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {g, 3'b0, gv, bz, sv, fl, num}, 32'd0);
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    check_all_zero("reset");

    // 1: answer 0123
    exp_q.push_back(16'h0123);
    do_start();
    check("t1_busy", 32'(bz), 32'd1);
    expect_guess("t1", 125);
    feed(4'd4, 4'd0);
    check("t1_solved", 32'(sv), 32'd1);
    check("t1_num", 32'(num), 32'd1);
    check("t1_busy_end", 32'(bz), 32'd0);
    check("t1_gv_end", 32'(gv), 32'd0);
    tick();
    check("t1_guess_held", 32'(g), 32'h0123);

    // 2: answer 4567
    exp_q.push_back(16'h0123);
    exp_q.push_back(16'h4567);
    do_start();
    check("t2_solved_cleared", 32'(sv), 32'd0);
    expect_guess("t2a", 125);
    feed(4'd0, 4'd0);
    expect_guess("t2b", -1);
    feed(4'd4, 4'd0);
    check("t2_solved", 32'(sv), 32'd1);
    check("t2_num", 32'(num), 32'd2);

    // 3: inconsistent feedback exhausts the search
    exp_q.push_back(16'h0123);
    exp_q.push_back(16'h4567);
    do_start();
    expect_guess("t3a", 125);
    feed(4'd0, 4'd0);
    expect_guess("t3b", -1);
    feed(4'd0, 4'd0);
    wait_end("t3");
    check("t3_fail", 32'(fl), 32'd1);
    check("t3_solved", 32'(sv), 32'd0);
    check("t3_num", 32'(num), 32'd2);

    // 5: stray result_valid in SEARCH and start in PRESENT are ignored
    exp_q.push_back(16'h0123);
    do_start();
    a_cnt        = 4'd4;
    b_cnt        = 4'd0;
    result_valid = 1'b1;
    tick();
    tick();
    tick();
    result_valid = 1'b0;
    expect_guess("t5a", 122);
    check("t5_num_a", 32'(num), 32'd0);
    check("t5_solved", 32'(sv), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("t5_gv_held", 32'(gv), 32'd1);
    check("t5_guess_held", 32'(g), 32'h0123);
    check("t5_busy_held", 32'(bz), 32'd1);
    exp_q.push_back(16'h4567);
    feed(4'd0, 4'd0);
    expect_guess("t5b", -1);
    check("t5_num_b", 32'(num), 32'd1);

    // 6: reset mid-SEARCH aborts the game
    feed(4'd1, 4'd1);
    repeat (5) tick();
    check("t6_busy_pre", 32'(bz), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_all_zero("t6_reset");
    exp_q.push_back(16'h0123);
    do_start();
    expect_guess("t6", 125);
    rst = 1'b0;
    tick();
    rst = 1'b1;

    // 4: MAX_GUESS=2, answer 9876
    sel = 1'b1;
    #1;
    check_all_zero("t4_reset");
    exp_q.push_back(16'h0123);
    exp_q.push_back(16'h4567);
    do_start();
    expect_guess("t4a", 125);
    feed(4'd0, 4'd0);
    expect_guess("t4b", -1);
    feed(4'd0, 4'd2);
    check("t4_fail", 32'(fl), 32'd1);
    check("t4_num", 32'(num), 32'd2);
    check("t4_solved", 32'(sv), 32'd0);
    check("t4_busy", 32'(bz), 32'd0);
    check("t4_sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
